// File: rtl/ctrl_sequencer_if.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer_if
//   Bundles the sequencer's instruction-memory, data-memory and datapath
//   control signals.
//
//   slave  : the sequencer side (consumes start/memory responses/flags,
//            drives fetch request, memory strobes and datapath controls)
//   master : the environment side (instruction memory, data memory,
//            datapath, or a testbench standing in for them)
//
//   Signals
//     start       begin execution from IDLE
//     imem_req    instruction fetch request
//     imem_valid  instruction word valid this cycle
//     instr[8:0]  instruction: [8:6] opcode, [5:0] operand fields
//     zero        datapath zero flag (BNE condition)
//     dmem_re/we  data-memory read/write strobes
//     dmem_ack    data-memory access complete
//     alu_op      opcode of the latched instruction
//     operand     operand fields of the latched instruction
//     reg_we      register-file write enable
//     pc_inc      PC += 1 this cycle
//     pc_load     PC <= branch target this cycle
//     done        sticky halt indicator
//     retired     saturating retired-instruction count
// ---------------------------------------------------------------------------
interface ctrl_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             imem_req;
    logic             imem_valid;
    logic [8:0]       instr;
    logic             zero;
    logic             dmem_re;
    logic             dmem_we;
    logic             dmem_ack;
    logic [2:0]       alu_op;
    logic [5:0]       operand;
    logic             reg_we;
    logic             pc_inc;
    logic             pc_load;
    logic             done;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  start, imem_valid, instr, zero, dmem_ack,
        output imem_req, dmem_re, dmem_we, alu_op, operand,
               reg_we, pc_inc, pc_load, done, retired
    );

    modport master (
        output start, imem_valid, instr, zero, dmem_ack,
        input  imem_req, dmem_re, dmem_we, alu_op, operand,
               reg_we, pc_inc, pc_load, done, retired
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
//   Multi-cycle control sequencer for the basic processor. Fetches a 9-bit
//   instruction, decodes its 3-bit opcode and drives the datapath strobes
//   one state per cycle: IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//   Unmapped opcode 111 parks the machine in HALT until reset. Counts
//   retired instructions with a saturating counter.
//
//   Ports
//     clk    single clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    ctrl_sequencer_if.slave (see interface for signal list)
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    ctrl_sequencer_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_LSH = 3'b001,
        OP_RSH = 3'b010,
        OP_XOR = 3'b011,
        OP_LD  = 3'b100,
        OP_SW  = 3'b101,
        OP_BNE = 3'b110,
        OP_HLT = 3'b111
    } opcode_t;

    state_t           state;
    state_t           state_nxt;
    logic [8:0]       ir;
    logic [CNT_W-1:0] retired;
    logic             capture;
    logic             retire;
    opcode_t          op;

    assign op          = opcode_t'(ir[8:6]);
    assign bus.alu_op  = ir[8:6];
    assign bus.operand = ir[5:0];
    assign bus.retired = retired;

    // Next-state and strobe decode. Each input is only looked at in the
    // state that owns it, so stray imem_valid/dmem_ack/zero are ignored.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned, which would infer a latch.
        state_nxt    = state;
        capture      = 1'b0;
        retire       = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_re  = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.reg_we   = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.done     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_valid) begin
                    capture   = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = (op == OP_HLT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                case (op)
                    OP_AND, OP_LSH, OP_RSH, OP_XOR: state_nxt = ST_WB;
                    OP_LD, OP_SW:                   state_nxt = ST_MEM;
                    OP_BNE: begin
                        // Branch taken when the datapath result is non-zero;
                        // exactly one of pc_load/pc_inc is asserted.
                        bus.pc_load = ~bus.zero;
                        bus.pc_inc  = bus.zero;
                        retire      = 1'b1;
                        state_nxt   = ST_FETCH;
                    end
                    default:                        state_nxt = ST_HALT;
                endcase
            end
            ST_MEM: begin
                // Strobe is held until ack; an ack in the first MEM cycle
                // completes the access in that same cycle.
                bus.dmem_re = (op == OP_LD);
                bus.dmem_we = (op != OP_LD);
                if (bus.dmem_ack) begin
                    if (op == OP_LD) begin
                        state_nxt = ST_WB;
                    end else begin
                        bus.pc_inc = 1'b1;
                        retire     = 1'b1;
                        state_nxt  = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                bus.reg_we = 1'b1;
                bus.pc_inc = 1'b1;
                retire     = 1'b1;
                state_nxt  = ST_FETCH;
            end
            ST_HALT: begin
                bus.done = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (capture) ir <= bus.instr;
            // Saturate at all-ones rather than wrapping.
            if (retire && (retired != '1)) retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_sequencer
//   Directed bench for ctrl_sequencer. A 16-bit-counter instance is driven
//   from a per-cycle vector table plus hand-written sequences (halt, reset
//   in MEM, counter saturation). A second instance with a 2-bit counter
//   sees identical stimulus so its saturation can be compared alongside.
// ---------------------------------------------------------------------------
module tb_ctrl_sequencer;

    localparam logic [8:0] I_XOR = 9'b011_000_001;
    localparam logic [8:0] I_BNE = 9'b110_000_010;
    localparam logic [8:0] I_SW  = 9'b101_000_011;
    localparam logic [8:0] I_LD  = 9'b100_000_100;
    localparam logic [8:0] I_HLT = 9'b111_111_111;

    logic clk;
    logic rst_n;

    ctrl_sequencer_if #(.CNT_W(16)) bus ();
    ctrl_sequencer_if #(.CNT_W(2))  bus_s ();

    ctrl_sequencer #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    ctrl_sequencer #(.CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    assign bus_s.start      = bus.start;
    assign bus_s.imem_valid = bus.imem_valid;
    assign bus_s.instr      = bus.instr;
    assign bus_s.zero       = bus.zero;
    assign bus_s.dmem_ack   = bus.dmem_ack;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Strobe bit order: imem_req dmem_re dmem_we reg_we pc_inc pc_load done
    typedef struct {
        logic       start;
        logic       ivalid;
        logic [8:0] instr;
        logic       zero;
        logic       ack;
        logic [6:0] strobes;
        logic [8:0] ir;
        int         ret;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.imem_req, bus.dmem_re, bus.dmem_we, bus.reg_we,
                bus.pc_inc, bus.pc_load, bus.done};
    endfunction

    function automatic vec_t v(input logic st, input logic iv,
                               input logic [8:0] ins, input logic z,
                               input logic ak, input logic [6:0] sb,
                               input logic [8:0] ir, input int ret);
        vec_t r;
        r.start = st; r.ivalid = iv; r.instr = ins; r.zero = z; r.ack = ak;
        r.strobes = sb; r.ir = ir; r.ret = ret;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start      = 1'b0;
        bus.imem_valid = 1'b0;
        bus.instr      = 9'd0;
        bus.zero       = 1'b0;
        bus.dmem_ack   = 1'b0;
    endtask

    // IDLE -> FETCH
    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Called in FETCH; returns in the following FETCH after retire.
    task automatic run_alu();
        bus.imem_valid = 1'b1;
        bus.instr      = I_XOR;
        step();
        bus.imem_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- per-cycle table: XOR, BNE taken, BNE not taken, SW, LD+3 wait
        //          st iv instr  z  ak  strobes      ir     ret
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0000000, 9'd0,  0)); // IDLE
        tbl.push_back(v(1, 0, 9'd0,  0, 0, 7'b0000000, 9'd0,  0)); // IDLE start
        tbl.push_back(v(0, 1, I_XOR, 0, 0, 7'b1000000, 9'd0,  0)); // FETCH
        tbl.push_back(v(1, 0, 9'd0,  0, 0, 7'b0000000, I_XOR, 0)); // DECODE
        tbl.push_back(v(0, 1, I_HLT, 0, 0, 7'b0000000, I_XOR, 0)); // EXEC
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0001100, I_XOR, 0)); // WB
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b1000000, I_XOR, 1)); // FETCH wait
        tbl.push_back(v(0, 1, I_BNE, 0, 0, 7'b1000000, I_XOR, 1)); // FETCH
        tbl.push_back(v(0, 0, 9'd0,  1, 0, 7'b0000000, I_BNE, 1)); // DECODE
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0000010, I_BNE, 1)); // EXEC load
        tbl.push_back(v(0, 1, I_BNE, 0, 1, 7'b1000000, I_BNE, 2)); // FETCH
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0000000, I_BNE, 2)); // DECODE
        tbl.push_back(v(0, 0, 9'd0,  1, 0, 7'b0000100, I_BNE, 2)); // EXEC inc
        tbl.push_back(v(0, 1, I_SW,  0, 0, 7'b1000000, I_BNE, 3)); // FETCH
        tbl.push_back(v(0, 0, 9'd0,  0, 1, 7'b0000000, I_SW,  3)); // DECODE
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0000000, I_SW,  3)); // EXEC
        tbl.push_back(v(0, 0, 9'd0,  0, 1, 7'b0010100, I_SW,  3)); // MEM ack
        tbl.push_back(v(0, 1, I_LD,  0, 0, 7'b1000000, I_SW,  4)); // FETCH
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0000000, I_LD,  4)); // DECODE
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0000000, I_LD,  4)); // EXEC
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0100000, I_LD,  4)); // MEM
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0100000, I_LD,  4)); // MEM
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0100000, I_LD,  4)); // MEM
        tbl.push_back(v(0, 0, 9'd0,  0, 1, 7'b0100000, I_LD,  4)); // MEM ack
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b0001100, I_LD,  4)); // WB
        tbl.push_back(v(0, 0, 9'd0,  0, 0, 7'b1000000, I_LD,  5)); // FETCH

        foreach (tbl[i]) begin
            bus.start      = tbl[i].start;
            bus.imem_valid = tbl[i].ivalid;
            bus.instr      = tbl[i].instr;
            bus.zero       = tbl[i].zero;
            bus.dmem_ack   = tbl[i].ack;
            #1;
            check($sformatf("row%0d_strobes", i), 32'(strobes()), 32'(tbl[i].strobes));
            check($sformatf("row%0d_ir", i), 32'({bus.alu_op, bus.operand}), 32'(tbl[i].ir));
            check($sformatf("row%0d_retired", i), 32'(bus.retired), 32'(tbl[i].ret));
            check($sformatf("row%0d_retired_small", i), 32'(bus_s.retired),
                  32'((tbl[i].ret > 3) ? 3 : tbl[i].ret));
            step();
        end
        clear_inputs();

        // ---- HALT: opcode 111 fetched, then stimulus must be ignored
        bus.imem_valid = 1'b1;
        bus.instr      = I_HLT;
        step();                         // DECODE
        clear_inputs();
        step();                         // HALT
        for (int k = 0; k < 3; k++) begin
            bus.start      = 1'b1;
            bus.imem_valid = 1'b1;
            bus.instr      = I_XOR;
            #1;
            check($sformatf("halt%0d_strobes", k), 32'(strobes()), 32'(7'b0000001));
            check($sformatf("halt%0d_ir", k), 32'({bus.alu_op, bus.operand}), 32'(I_HLT));
            check($sformatf("halt%0d_retired", k), 32'(bus.retired), 32'd5);
            step();
        end
        clear_inputs();

        // ---- Reset out of HALT, two ALU ops, then reset while SW is in MEM
        rst_n = 1'b0;
        #1;
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ir", 32'({bus.alu_op, bus.operand}), 32'd0);
        step();
        rst_n = 1'b1;
        do_start();
        run_alu();
        run_alu();
        check("two_alu_retired", 32'(bus.retired), 32'd2);
        check("two_alu_retired_small", 32'(bus_s.retired), 32'd2);
        bus.imem_valid = 1'b1;
        bus.instr      = I_SW;
        step();
        clear_inputs();
        for (int k = 0; k < 10 && !bus.dmem_we; k++) step();
        check("sw_reached_mem", 32'(bus.dmem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mem_strobes", 32'(strobes()), 32'd0);
        check("rst_mem_retired", 32'(bus.retired), 32'd0);
        check("rst_mem_ir", 32'({bus.alu_op, bus.operand}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 32'(strobes()), 32'd0);

        // ---- Saturation: five ALU ops, 2-bit counter stops at 3
        do_start();
        for (int k = 0; k < 5; k++) run_alu();
        check("sat_retired", 32'(bus.retired), 32'd5);
        check("sat_retired_small", 32'(bus_s.retired), 32'd3);
        check("sat_fetch_again", 32'(bus.imem_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
